// File: rtl/xfire_link_rx.sv
// Receive deframer for the xfire byte link: sync hunt, length-prefixed payload, XOR checksum.
// Optional saturating frame statistics when XFIRE_LINK_RX_STATS_EN is defined.
module xfire_link_rx #(
    parameter logic [7:0] SYNC_BYTE = 8'hA5,
    parameter int         MAX_LEN   = 64,
    parameter int         TIMEOUT   = 256,
    parameter int         CNT_W     = 16
) (
    input  logic       clk,
    input  logic       arst,
    input  logic       srst,
    input  logic       enable,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic [7:0] out_data,
    output logic       out_valid,
    output logic       out_last,
    output logic       frame_ok,
    output logic       frame_err,
    output logic [1:0] err_code,
    output logic       busy
`ifdef XFIRE_LINK_RX_STATS_EN
    ,
    input  logic             stats_clr,
    output logic [CNT_W-1:0] ok_cnt,
    output logic [CNT_W-1:0] err_cnt
`endif
);

    localparam logic [1:0] HUNT    = 2'd0;
    localparam logic [1:0] LEN     = 2'd1;
    localparam logic [1:0] PAYLOAD = 2'd2;
    localparam logic [1:0] CHK     = 2'd3;

    localparam int          TW      = $clog2(TIMEOUT);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
    localparam logic [7:0]  MAX_B   = 8'(MAX_LEN);

    if (MAX_LEN < 1 || MAX_LEN > 255) begin : g_bad_max_len
        $error("MAX_LEN out of range");
    end
    if (TIMEOUT < 2) begin : g_bad_timeout
        $error("TIMEOUT must be at least 2");
    end
    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("CNT_W must be at least 1");
    end

    logic [1:0]    state_q, state_d;
    logic [7:0]    rem_q, rem_d;
    logic [7:0]    acc_q, acc_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [7:0]    out_data_q, out_data_d;
    logic          out_valid_q, out_valid_d;
    logic          out_last_q, out_last_d;
    logic          frame_ok_q, frame_ok_d;
    logic          frame_err_q, frame_err_d;
    logic [1:0]    err_code_q, err_code_d;

    always_comb begin
        state_d     = state_q;
        rem_d       = rem_q;
        acc_d       = acc_q;
        tmo_d       = tmo_q;
        out_data_d  = out_data_q;
        err_code_d  = err_code_q;
        out_valid_d = 1'b0;
        out_last_d  = 1'b0;
        frame_ok_d  = 1'b0;
        frame_err_d = 1'b0;

        if (enable) begin
            if (in_valid) begin
                tmo_d = '0;
                case (state_q)
                    HUNT: if (in_data == SYNC_BYTE) state_d = LEN;
                    LEN: begin
                        if (in_data == 8'd0 || in_data > MAX_B) begin
                            frame_err_d = 1'b1;
                            err_code_d  = 2'd1;
                            state_d     = HUNT;
                        end else begin
                            rem_d   = in_data;
                            acc_d   = in_data;
                            state_d = PAYLOAD;
                        end
                    end
                    PAYLOAD: begin
                        out_data_d  = in_data;
                        out_valid_d = 1'b1;
                        acc_d       = acc_q ^ in_data;
                        rem_d       = rem_q - 8'd1;
                        if (rem_q == 8'd1) begin
                            out_last_d = 1'b1;
                            state_d    = CHK;
                        end
                    end
                    default: begin
                        if (in_data == acc_q) begin
                            frame_ok_d = 1'b1;
                        end else begin
                            frame_err_d = 1'b1;
                            err_code_d  = 2'd0;
                        end
                        state_d = HUNT;
                    end
                endcase
            end else if (state_q != HUNT) begin
                // Idle gap mid-frame: abort once TIMEOUT enabled idle cycles have elapsed.
                if (tmo_q == TMO_LAST) begin
                    tmo_d       = '0;
                    frame_err_d = 1'b1;
                    err_code_d  = 2'd2;
                    state_d     = HUNT;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
        end

        if (srst) begin
            state_d     = HUNT;
            rem_d       = '0;
            acc_d       = '0;
            tmo_d       = '0;
            out_data_d  = '0;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            frame_ok_d  = 1'b0;
            frame_err_d = 1'b0;
            err_code_d  = 2'd0;
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q     <= HUNT;
            rem_q       <= '0;
            acc_q       <= '0;
            tmo_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            frame_ok_q  <= 1'b0;
            frame_err_q <= 1'b0;
            err_code_q  <= 2'd0;
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            acc_q       <= acc_d;
            tmo_q       <= tmo_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            frame_ok_q  <= frame_ok_d;
            frame_err_q <= frame_err_d;
            err_code_q  <= err_code_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign frame_ok  = frame_ok_q;
    assign frame_err = frame_err_q;
    assign err_code  = err_code_q;
    assign busy      = (state_q != HUNT);

`ifdef XFIRE_LINK_RX_STATS_EN
    logic [CNT_W-1:0] ok_cnt_q, ok_cnt_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

    // Counters step with the pulse they count; clear beats a same-cycle increment.
    always_comb begin
        ok_cnt_d  = ok_cnt_q;
        err_cnt_d = err_cnt_q;
        if (enable) begin
            if (stats_clr) begin
                ok_cnt_d  = '0;
                err_cnt_d = '0;
            end else begin
                if (frame_ok_d && ok_cnt_q != '1)   ok_cnt_d  = ok_cnt_q + CNT_W'(1);
                if (frame_err_d && err_cnt_q != '1) err_cnt_d = err_cnt_q + CNT_W'(1);
            end
        end
        if (srst) begin
            ok_cnt_d  = '0;
            err_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            ok_cnt_q  <= '0;
            err_cnt_q <= '0;
        end else begin
            ok_cnt_q  <= ok_cnt_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign ok_cnt  = ok_cnt_q;
    assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_xfire_link_rx.sv
// Directed bench for xfire_link_rx: vector table plus hand sequences for timeout, enable, resets, stats.
module tb_xfire_link_rx;

    localparam int CW = 2;

    logic       clk = 1'b0;
    logic       arst, srst, enable, in_valid;
    logic [7:0] in_data;
    logic [7:0] out_data;
    logic       out_valid, out_last, frame_ok, frame_err, busy;
    logic [1:0] err_code;
`ifdef XFIRE_LINK_RX_STATS_EN
    logic          stats_clr;
    logic [CW-1:0] ok_cnt, err_cnt;
`endif

    xfire_link_rx #(.SYNC_BYTE(8'hA5), .MAX_LEN(64), .TIMEOUT(256), .CNT_W(CW)) dut (
        .clk(clk), .arst(arst), .srst(srst), .enable(enable),
        .in_data(in_data), .in_valid(in_valid),
        .out_data(out_data), .out_valid(out_valid), .out_last(out_last),
        .frame_ok(frame_ok), .frame_err(frame_err), .err_code(err_code), .busy(busy)
`ifdef XFIRE_LINK_RX_STATS_EN
        , .stats_clr(stats_clr), .ok_cnt(ok_cnt), .err_cnt(err_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       v;
        logic [7:0] d;
        logic       ov;
        logic [7:0] od;
        logic       ol;
        logic       ok;
        logic       er;
        logic [1:0] ec;
        logic       bz;
    } vec_t;

    vec_t vecs[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    function automatic vec_t mk(logic v, logic [7:0] d, logic ov, logic [7:0] od, logic ol,
                                logic ok, logic er, logic [1:0] ec, logic bz);
        vec_t t;
        t.v = v; t.d = d; t.ov = ov; t.od = od; t.ol = ol;
        t.ok = ok; t.er = er; t.ec = ec; t.bz = bz;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Present one byte (or an idle slot) for a clock; outputs are sampled 1 time unit after the edge.
    task automatic cyc(input logic v, input logic [7:0] d);
        in_valid = v;
        in_data  = d;
        @(posedge clk);
        #1;
    endtask

    task automatic flags(input string nm, input logic [4:0] exp);
        chk(nm, {27'd0, out_valid, out_last, frame_ok, frame_err, busy}, {27'd0, exp});
    endtask

    // Single-byte frame: A5, 01, x, then checksum (good: 01^x).
    task automatic frame1(input logic [7:0] x, input logic good);
        cyc(1, 8'hA5);
        cyc(1, 8'h01);
        cyc(1, x);
        cyc(1, good ? (x ^ 8'h01) : (x ^ 8'h80));
    endtask

    initial begin
        logic saw_err;
        arst = 1'b1; srst = 1'b0; enable = 1'b1; in_valid = 1'b0; in_data = 8'h00;
`ifdef XFIRE_LINK_RX_STATS_EN
        stats_clr = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1 arst = 1'b0;
        #1;
        flags("reset_flags", 5'b00000);
        chk("reset_data", {24'd0, out_data}, 32'h0);
        chk("reset_code", {30'd0, err_code}, 32'h0);

        //                v  d      ov od     ol ok er ec    bz
        vecs.push_back(mk(1, 8'h00, 0, 8'h00, 0, 0, 0, 2'd0, 0));
        vecs.push_back(mk(1, 8'hFF, 0, 8'h00, 0, 0, 0, 2'd0, 0));
        vecs.push_back(mk(1, 8'h5A, 0, 8'h00, 0, 0, 0, 2'd0, 0));
        vecs.push_back(mk(0, 8'hA5, 0, 8'h00, 0, 0, 0, 2'd0, 0));
        vecs.push_back(mk(1, 8'hA5, 0, 8'h00, 0, 0, 0, 2'd0, 1));
        vecs.push_back(mk(1, 8'h03, 0, 8'h00, 0, 0, 0, 2'd0, 1));
        vecs.push_back(mk(1, 8'h11, 1, 8'h11, 0, 0, 0, 2'd0, 1));
        vecs.push_back(mk(1, 8'h22, 1, 8'h22, 0, 0, 0, 2'd0, 1));
        vecs.push_back(mk(1, 8'h33, 1, 8'h33, 1, 0, 0, 2'd0, 1));
        vecs.push_back(mk(1, 8'h03, 0, 8'h00, 0, 1, 0, 2'd0, 0));
        vecs.push_back(mk(1, 8'hA5, 0, 8'h00, 0, 0, 0, 2'd0, 1));
        vecs.push_back(mk(1, 8'h02, 0, 8'h00, 0, 0, 0, 2'd0, 1));
        vecs.push_back(mk(1, 8'h10, 1, 8'h10, 0, 0, 0, 2'd0, 1));
        vecs.push_back(mk(1, 8'h20, 1, 8'h20, 1, 0, 0, 2'd0, 1));
        vecs.push_back(mk(1, 8'h00, 0, 8'h00, 0, 0, 1, 2'd0, 0));
        vecs.push_back(mk(1, 8'hA5, 0, 8'h00, 0, 0, 0, 2'd0, 1));
        vecs.push_back(mk(1, 8'h00, 0, 8'h00, 0, 0, 1, 2'd1, 0));
        vecs.push_back(mk(1, 8'hA5, 0, 8'h00, 0, 0, 0, 2'd0, 1));
        vecs.push_back(mk(1, 8'h41, 0, 8'h00, 0, 0, 1, 2'd1, 0));
        vecs.push_back(mk(1, 8'hA5, 0, 8'h00, 0, 0, 0, 2'd0, 1));
        vecs.push_back(mk(1, 8'h01, 0, 8'h00, 0, 0, 0, 2'd0, 1));
        vecs.push_back(mk(1, 8'hA5, 1, 8'hA5, 1, 0, 0, 2'd0, 1));
        vecs.push_back(mk(1, 8'hA4, 0, 8'h00, 0, 1, 0, 2'd0, 0));
        vecs.push_back(mk(1, 8'hA5, 0, 8'h00, 0, 0, 0, 2'd0, 1));
        vecs.push_back(mk(1, 8'h40, 0, 8'h00, 0, 0, 0, 2'd0, 1));

        foreach (vecs[i]) begin
            cyc(vecs[i].v, vecs[i].d);
            flags($sformatf("vec%0d_flags", i),
                  {vecs[i].ov, vecs[i].ol, vecs[i].ok, vecs[i].er, vecs[i].bz});
            if (vecs[i].ov) chk($sformatf("vec%0d_data", i), {24'd0, out_data}, {24'd0, vecs[i].od});
            if (vecs[i].er) chk($sformatf("vec%0d_code", i), {30'd0, err_code}, {30'd0, vecs[i].ec});
        end

        // Length 64 frame in flight; abandon it with srst mid-payload.
        cyc(1, 8'h11);
        srst = 1'b1;
        cyc(1, 8'h22);
        srst = 1'b0;
        flags("srst_flags", 5'b00000);
        chk("srst_data", {24'd0, out_data}, 32'h0);
        frame1(8'h7E, 1'b1);
        flags("after_srst_ok", 5'b00100);

        // Timeout: 255 idle cycles are tolerated, the 256th aborts.
        cyc(1, 8'hA5);
        cyc(1, 8'h04);
        cyc(1, 8'h01);
        saw_err = 1'b0;
        for (int k = 0; k < 255; k++) begin
            cyc(0, 8'h00);
            if (frame_err || !busy) saw_err = 1'b1;
        end
        chk("gap255_no_abort", {31'd0, saw_err}, 32'd0);
        cyc(1, 8'h02);
        flags("gap255_byte", 5'b10001);
        chk("gap255_data", {24'd0, out_data}, 32'h02);
        saw_err = 1'b0;
        for (int k = 0; k < 255; k++) begin
            cyc(0, 8'h00);
            if (frame_err) saw_err = 1'b1;
        end
        chk("tmo_early", {31'd0, saw_err}, 32'd0);
        cyc(0, 8'h00);
        flags("tmo_flags", 5'b00010);
        chk("tmo_code", {30'd0, err_code}, 32'd2);
        cyc(0, 8'h00);
        flags("tmo_one_pulse", 5'b00000);

        // Enable low with bytes presented: ignored, state held.
        cyc(1, 8'hA5);
        cyc(1, 8'h02);
        enable = 1'b0;
        saw_err = 1'b0;
        for (int k = 0; k < 10; k++) begin
            cyc(1, 8'h77);
            if (out_valid || !busy || frame_err || frame_ok) saw_err = 1'b1;
        end
        chk("enable_low_hold", {31'd0, saw_err}, 32'd0);
        enable = 1'b1;
        cyc(1, 8'h10);
        flags("en_b0", 5'b10001);
        cyc(1, 8'h20);
        flags("en_b1", 5'b11001);
        cyc(1, 8'h32);
        flags("en_chk", 5'b00100);

        // Pulses drop while disabled, out_data holds.
        cyc(1, 8'hA5);
        cyc(1, 8'h01);
        cyc(1, 8'h55);
        flags("pulse_pre", 5'b11001);
        enable = 1'b0;
        cyc(1, 8'h99);
        enable = 1'b1;
        flags("pulse_drop", 5'b00001);
        chk("pulse_hold_data", {24'd0, out_data}, 32'h55);
        cyc(1, 8'h54);
        flags("pulse_chk", 5'b00100);

        // Asynchronous reset mid-frame takes effect without a clock edge.
        cyc(1, 8'hA5);
        cyc(1, 8'h02);
        cyc(1, 8'h10);
        #2 arst = 1'b1;
        #1;
        flags("arst_flags", 5'b00000);
        @(posedge clk);
        #1 arst = 1'b0;
        frame1(8'h3C, 1'b1);
        flags("after_arst_ok", 5'b00100);

`ifdef XFIRE_LINK_RX_STATS_EN
        stats_clr = 1'b1;
        cyc(0, 8'h00);
        stats_clr = 1'b0;
        chk("st_clr_ok", {{(32-CW){1'b0}}, ok_cnt}, 32'd0);
        chk("st_clr_err", {{(32-CW){1'b0}}, err_cnt}, 32'd0);
        frame1(8'h01, 1'b1);
        frame1(8'h02, 1'b1);
        frame1(8'h03, 1'b0);
        frame1(8'h04, 1'b1);
        chk("st_ok3", {{(32-CW){1'b0}}, ok_cnt}, 32'd3);
        chk("st_err1", {{(32-CW){1'b0}}, err_cnt}, 32'd1);
        frame1(8'h05, 1'b1);
        chk("st_ok_sat", {{(32-CW){1'b0}}, ok_cnt}, 32'd3);
        cyc(1, 8'hA5);
        cyc(1, 8'h01);
        cyc(1, 8'h06);
        stats_clr = 1'b1;
        cyc(1, 8'h07);
        stats_clr = 1'b0;
        flags("st_clr_frame_ok", 5'b00100);
        chk("st_clr_wins", {{(32-CW){1'b0}}, ok_cnt}, 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
